// File: rtl/systolic_skew_feeder_if.sv
// Operand load port for the systolic skew feeder: valid/ready write into the A/B banks.
// The master drives a write request and the slave answers with ld_ready.
interface systolic_skew_feeder_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int AW = $clog2(N*N);

  logic                         ld_valid;
  logic                         ld_ready;
  logic                         ld_sel;
  logic [AW-1:0]                ld_addr;
  logic signed [DATA_WIDTH-1:0] ld_data;

  modport master (output ld_valid, ld_sel, ld_addr, ld_data, input ld_ready);
  modport slave  (input ld_valid, ld_sel, ld_addr, ld_data, output ld_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Stages an NxN A/B tile pair and injects it into an output-stationary systolic array
// with diagonal skew, clearing the array first and flagging done once the wavefront drains.
module systolic_skew_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  systolic_skew_feeder_if.slave     ld,
  input  logic                      start,
  output logic [N*DATA_WIDTH-1:0]   a_out,
  output logic [N*DATA_WIDTH-1:0]   b_out,
  output logic                      arr_rst_n,
  output logic                      busy,
  output logic                      done
);
  localparam int AW = $clog2(N*N);
  localparam int CW = $clog2(2*N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                   state, state_nxt;
  logic [CW-1:0]                cnt, cnt_nxt;
  logic signed [DATA_WIDTH-1:0] bank_a [N*N];
  logic signed [DATA_WIDTH-1:0] bank_b [N*N];
  logic [N*DATA_WIDTH-1:0]      a_nxt, b_nxt;
  logic                         ld_fire;
  logic                         ld_in_range;
  int                           feed_t;

  assign ld.ld_ready   = (state == S_IDLE) && !rst;
  assign ld_fire       = ld.ld_valid && ld.ld_ready;
  assign ld_in_range   = {1'b0, ld.ld_addr} < (AW+1)'(N*N);
  assign feed_t        = int'(cnt_nxt);

  // cnt is the feed index t in FEED and the drain count in FLUSH
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLEAR;
          cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        state_nxt = S_FEED;
        cnt_nxt   = '0;
      end
      S_FEED: begin
        if (cnt == CW'(2*N-2)) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_FLUSH: begin
        if (cnt == CW'(N-2)) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Operands for the upcoming cycle; row i / column j lag the feed index by i / j
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    if (state_nxt == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        if (feed_t >= i && feed_t - i < N) begin
          a_nxt[i*DATA_WIDTH +: DATA_WIDTH] = bank_a[AW'(i*N + feed_t - i)];
          b_nxt[i*DATA_WIDTH +: DATA_WIDTH] = bank_b[AW'((feed_t - i)*N + i)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_out     <= '0;
      b_out     <= '0;
      arr_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int n = 0; n < N*N; n++) begin
        bank_a[n] <= '0;
        bank_b[n] <= '0;
      end
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      a_out     <= a_nxt;
      b_out     <= b_nxt;
      arr_rst_n <= (state_nxt != S_CLEAR);
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
      if (ld_fire && ld_in_range) begin
        if (ld.ld_sel)
          bank_b[ld.ld_addr] <= ld.ld_data;
        else
          bank_a[ld.ld_addr] <= ld.ld_data;
      end
    end
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: randomized loads/runs against a cycle-table model,
// with the array's products rebuilt from the injected operand streams.
module tb_systolic_skew_feeder;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int AW  = $clog2(N*N);
  localparam int RUN = 3*N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N*DW-1:0] a_out, b_out;
  logic          arr_rst_n, busy, done;

  systolic_skew_feeder_if #(.N(N), .DATA_WIDTH(DW)) ld_bus ();

  systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld_bus),
    .start     (start),
    .a_out     (a_out),
    .b_out     (b_out),
    .arr_rst_n (arr_rst_n),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bank contents as matrices plus the cycle index within a run (0 = idle)
  int     ref_a [N][N];
  int     ref_b [N][N];
  int     m_cyc   = 0;
  logic   m_rst   = 1'b1;
  logic   m_valid = 1'b0;

  int     tb_a [N][N];
  int     tb_b [N][N];
  longint cap_a [RUN+1][N];
  longint cap_b [RUN+1][N];
  logic   cap_arst [RUN+1];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint model_c(input int i, input int j);
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'(ref_a[i][k]) * longint'(ref_b[k][j]);
    return s;
  endfunction

  // PE(i,j) multiplies row i as injected j cycles earlier with column j as injected i cycles earlier
  function automatic longint psum(input int i, input int j);
    longint s = 0;
    for (int x = 2; x <= RUN-1; x++) begin
      if (x - j >= 1 && x - i >= 1) s += cap_a[x-j][i] * cap_b[x-i][j];
    end
    return s;
  endfunction

  always @(posedge clk) begin
    m_valid <= 1'b1;
    m_rst   <= rst;
    if (rst) begin
      m_cyc <= 0;
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          ref_a[i][k] <= 0;
          ref_b[i][k] <= 0;
        end
    end else if (m_cyc == 0) begin
      if (ld_bus.ld_valid && int'(ld_bus.ld_addr) < N*N) begin
        if (ld_bus.ld_sel)
          ref_b[int'(ld_bus.ld_addr) / N][int'(ld_bus.ld_addr) % N] <= int'(ld_bus.ld_data);
        else
          ref_a[int'(ld_bus.ld_addr) / N][int'(ld_bus.ld_addr) % N] <= int'(ld_bus.ld_data);
      end
      if (start) m_cyc <= 1;
    end else begin
      m_cyc <= (m_cyc == RUN) ? 0 : m_cyc + 1;
    end
  end

  always @(negedge clk) begin : cmp
    int     t;
    longint ea, eb;
    if (m_valid) begin
      t = m_cyc - 2;
      for (int i = 0; i < N; i++) begin
        ea = 0;
        eb = 0;
        if (m_cyc >= 2 && m_cyc <= 2*N && t - i >= 0 && t - i < N) begin
          ea = ref_a[i][t-i];
          eb = ref_b[t-i][i];
        end
        checkOutput($sformatf("a_out[%0d] cyc%0d", i, m_cyc), longint'($signed(a_out[i*DW +: DW])), ea);
        checkOutput($sformatf("b_out[%0d] cyc%0d", i, m_cyc), longint'($signed(b_out[i*DW +: DW])), eb);
      end
      checkOutput($sformatf("busy cyc%0d", m_cyc), longint'(busy), longint'(m_cyc != 0));
      checkOutput($sformatf("done cyc%0d", m_cyc), longint'(done), longint'(m_cyc == RUN));
      checkOutput($sformatf("arr_rst_n cyc%0d", m_cyc), longint'(arr_rst_n), longint'(!(m_rst || m_cyc == 1)));
      checkOutput($sformatf("ld_ready cyc%0d", m_cyc), longint'(ld_bus.ld_ready), longint'(m_cyc == 0 && !rst));
      if (m_cyc == 1) begin
        for (int c = 0; c <= RUN; c++) begin
          cap_arst[c] = 1'b1;
          for (int i = 0; i < N; i++) begin
            cap_a[c][i] = 0;
            cap_b[c][i] = 0;
          end
        end
      end
      if (m_cyc >= 1 && m_cyc < RUN) begin
        cap_arst[m_cyc] = arr_rst_n;
        for (int i = 0; i < N; i++) begin
          cap_a[m_cyc][i] = longint'($signed(a_out[i*DW +: DW]));
          cap_b[m_cyc][i] = longint'($signed(b_out[i*DW +: DW]));
        end
      end
      if (m_cyc == RUN) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            checkOutput($sformatf("psum(%0d,%0d)", i, j), psum(i, j), model_c(i, j));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic sel, input int addr, input int data, input logic st);
    ld_bus.ld_valid = v;
    ld_bus.ld_sel   = sel;
    ld_bus.ld_addr  = AW'(addr);
    ld_bus.ld_data  = DW'(data);
    start           = st;
    @(posedge clk);
    #2;
    ld_bus.ld_valid = 1'b0;
    start           = 1'b0;
  endtask

  // Loads tb_a and tb_b with random idle gaps; optionally fuses start onto the final word
  task automatic loadBanks(input logic start_on_last);
    for (int s = 0; s < 2; s++)
      for (int n = 0; n < N*N; n++) begin
        if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b1, s[0], n, (s == 0) ? tb_a[n/N][n%N] : tb_b[n/N][n%N],
                      start_on_last && s == 1 && n == N*N-1);
      end
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = c;
        break;
      end
    end
    checkOutput("done cycle", cyc, RUN);
    @(posedge clk);
    #2;
  endtask

  task automatic runAndWait(output int cyc);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    waitDone(cyc);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int     cyc;
    int     dones;
    longint first;
    rst             = 1'b1;
    start           = 1'b0;
    ld_bus.ld_valid = 1'b0;
    ld_bus.ld_sel   = 1'b0;
    ld_bus.ld_addr  = '0;
    ld_bus.ld_data  = '0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset busy", longint'(busy), 0);
    checkOutput("reset arr_rst_n", longint'(arr_rst_n), 0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    $display("[TB] identity run");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tb_a[i][j] = (i == j) ? 1 : 0;
        tb_b[i][j] = 4*i + j + 1;
      end
    loadBanks(1'b0);
    runAndWait(cyc);
    checkOutput("identity done at 12", cyc, 12);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        checkOutput($sformatf("identity psum(%0d,%0d)", i, j), psum(i, j), 4*i + j + 1);
    for (int c = 1; c < RUN; c++)
      checkOutput($sformatf("identity arr_rst_n cyc%0d", c), longint'(cap_arst[c]), longint'(c != 1));

    $display("[TB] skew run");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tb_a[i][j] = 16*i + j + 1;
        tb_b[i][j] = 16*i + j + 1;
      end
    loadBanks(1'b0);
    runAndWait(cyc);
    checkOutput("skew t3 row0", cap_a[5][0], 4);
    checkOutput("skew t3 row3", cap_a[5][3], 49);
    checkOutput("skew t3 col2", cap_b[5][2], 19);
    checkOutput("skew t6 row3", cap_a[8][3], 52);
    checkOutput("skew t6 col3", cap_b[8][3], 52);
    for (int i = 0; i < N-1; i++) begin
      checkOutput($sformatf("skew t6 row%0d", i), cap_a[8][i], 0);
      checkOutput($sformatf("skew t6 col%0d", i), cap_b[8][i], 0);
    end

    $display("[TB] signed run and rerun");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tb_a[i][j] = -3;
        tb_b[i][j] = 7;
      end
    loadBanks(1'b0);
    for (int r = 0; r < 2; r++) begin
      runAndWait(cyc);
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          checkOutput($sformatf("signed run%0d psum(%0d,%0d)", r, i, j), psum(i, j), -84);
    end

    $display("[TB] busy protection");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tb_a[i][j] = int'($urandom_range(0, 200)) - 100;
        tb_b[i][j] = int'($urandom_range(0, 200)) - 100;
      end
    loadBanks(1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    checkOutput("ld_ready in FEED", longint'(ld_bus.ld_ready), 0);
    applyStimulus(1'b1, 1'b0, 5, 99, 1'b1);
    applyStimulus(1'b1, 1'b1, 6, 99, 1'b0);
    first = 0;
    dones = 0;
    for (int c = 4; c <= RUN + 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (c == RUN - 1) first = psum(1, 1);
    end
    checkOutput("single done", dones, 1);
    @(posedge clk);
    #2;
    runAndWait(cyc);
    checkOutput("bank unchanged psum(1,1)", psum(1, 1), first);

    $display("[TB] reset mid-FEED");
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", longint'(busy), 0);
    checkOutput("abort arr_rst_n", longint'(arr_rst_n), 0);
    checkOutput("abort a_out", longint'(a_out), 0);
    checkOutput("abort b_out", longint'(b_out), 0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checkOutput("abort no done", dones, 0);
    @(posedge clk);
    #2;
    runAndWait(cyc);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        checkOutput($sformatf("after reset psum(%0d,%0d)", i, j), psum(i, j), 0);

    $display("[TB] load with start");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tb_a[i][j] = int'($urandom_range(0, 20)) - 10;
        tb_b[i][j] = (i == j) ? 1 : 0;
      end
    loadBanks(1'b0);
    applyStimulus(1'b1, 1'b0, 0, 5, 1'b1);
    waitDone(cyc);
    checkOutput("load+start psum(0,0)", psum(0, 0), 5);

    $display("[TB] random runs");
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          tb_a[i][j] = int'($urandom_range(0, 400)) - 200;
          tb_b[i][j] = int'($urandom_range(0, 400)) - 200;
        end
      if (r % 2 == 0) begin
        loadBanks(1'b1);
        waitDone(cyc);
      end else begin
        loadBanks(1'b0);
        repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
        runAndWait(cyc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
